// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch unit's redirect, instruction-memory and
// decode-side handshake signals. The master modport is the fetch unit itself;
// the slave modport is its environment (memory, decode, branch resolution).
interface fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_fault;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  if_ready,
        output imem_req_valid, imem_req_addr,
        output if_valid, if_instr, if_pc,
        output fetch_fault
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output if_ready,
        input  imem_req_valid, imem_req_addr,
        input  if_valid, if_instr, if_pc,
        input  fetch_fault
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction fetch front end. Owns the PC, issues one word
// request at a time to instruction memory, buffers the returned instruction
// with its address for decode, and takes next-PC redirects from branch
// resolution. Wrong-path responses are drained and discarded.
// Optional feature: define FETCH_ALIGN_CHECK_EN to trap misaligned redirect
// targets into a sticky FAULT state; without it the low two target bits are
// cleared and fetch_fault is tied low.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
`ifdef FETCH_ALIGN_CHECK_EN
        , FAULT = 3'd5
`endif
    } fetchState_t;

    fetchState_t state;
    fetchState_t nextState;
    fetchState_t resumeState;   // where to go once nothing is in flight after a redirect

    logic [31:0] pc;            // next fetch address
    logic [31:0] tagPc;         // address of the outstanding request
    logic [31:0] ifInstr;
    logic [31:0] ifPc;

    logic        reqFire;
    logic        respSeen;
    logic        redirectTaken;
    logic [31:0] redirectTarget;

    assign reqFire  = (state == ISSUE) && bus.imem_req_ready;
    assign respSeen = bus.imem_resp_valid;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fetchFault;
    logic misaligned;

    // Once faulted, redirects are ignored; only reset leaves FAULT.
    assign redirectTaken  = bus.redirect_valid && (state != FAULT);
    assign misaligned     = redirectTaken && (bus.redirect_pc[1:0] != 2'b00);
    assign redirectTarget = bus.redirect_pc;
    assign resumeState    = (misaligned || fetchFault) ? FAULT : ISSUE;
`else
    assign redirectTaken  = bus.redirect_valid;
    assign redirectTarget = bus.redirect_pc & 32'hFFFF_FFFC;
    assign resumeState    = ISSUE;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block ordering.
            state <= nextState;
        end
    end

    // Next-state logic: sequential flow plus redirect/drain handling.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // nextState unassigned and infers a latch.
        nextState = state;
        case (state)
            IDLE:  nextState = resumeState;
            ISSUE: begin
                if (reqFire) begin
                    nextState = redirectTaken ? DRAIN : WAIT;
                end else begin
                    nextState = resumeState;
                end
            end
            WAIT: begin
                if (redirectTaken) begin
                    nextState = respSeen ? resumeState : DRAIN;
                end else if (respSeen) begin
                    nextState = HOLD;
                end
            end
            HOLD: begin
                if (redirectTaken) begin
                    nextState = resumeState;
                end else if (bus.if_ready) begin
                    nextState = ISSUE;
                end
            end
            DRAIN: begin
                if (respSeen) begin
                    nextState = resumeState;
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            FAULT: nextState = FAULT;
`endif
            default: nextState = IDLE;
        endcase
    end

    // Datapath registers: PC, request tag, decode buffer and fault flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            tagPc      <= 32'h0;
            ifInstr    <= 32'h0;
            ifPc       <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
            fetchFault <= 1'b0;
`endif
        end else begin
            if (redirectTaken) begin
                pc <= redirectTarget;
            end else if (reqFire) begin
                pc <= pc + 32'd4;
            end
            if (reqFire) begin
                tagPc <= pc;
            end
            if ((state == WAIT) && respSeen && !redirectTaken) begin
                ifInstr <= bus.imem_resp_data;
                ifPc    <= tagPc;
            end
`ifdef FETCH_ALIGN_CHECK_EN
            if (misaligned) begin
                fetchFault <= 1'b1;
            end
`endif
        end
    end

    // Outputs decoded from state and registered datapath.
    always_comb begin
        bus.imem_req_valid = (state == ISSUE);
        bus.imem_req_addr  = pc;
        bus.if_valid       = (state == HOLD);
        bus.if_instr       = ifInstr;
        bus.if_pc          = ifPc;
`ifdef FETCH_ALIGN_CHECK_EN
        bus.fetch_fault    = fetchFault;
`else
        bus.fetch_fault    = 1'b0;
`endif
    end

endmodule
